// File: rtl/divider_seq.sv
// Multi-cycle restoring divider for DIV/IDIV, 16/8 and 32/16 forms.
// Errors flag divide-by-zero and quotient overflow for the INT 0 path.
module divider_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        is_8_bit,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        busy,
    output logic        complete,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_DIVIDE, S_FIXUP, S_DONE
    } state_t;

    state_t      r_state;
    logic        r_m8;
    logic        r_sgn;
    logic        r_negq;
    logic        r_negr;
    logic        r_err;
    logic [31:0] r_dvd;
    logic [15:0] r_dvs;
    logic [15:0] r_rem;
    logic [15:0] r_quo;
    logic [4:0]  r_cnt;

    logic        w_dvd_neg;
    logic        w_dvs_neg;
    logic [31:0] w_dvd_raw;
    logic [31:0] w_dvd_sx;
    logic [31:0] w_dvd_mag;
    logic [15:0] w_dvs_raw;
    logic [15:0] w_dvs_sx;
    logic [15:0] w_dvs_mag;
    logic [15:0] w_hi;
    logic [15:0] w_lo;
    logic        w_setup_err;
    logic [16:0] w_sh;
    logic        w_ge;
    logic [15:0] w_sub;
    logic [15:0] w_qmag;
    logic [15:0] w_rmag;
    logic [15:0] w_qs;
    logic [15:0] w_rs;
    logic [15:0] w_mask;
    logic [15:0] w_lim;
    logic        w_ovf;
    logic        w_fail;

    assign w_dvd_neg = r_sgn & (r_m8 ? r_dvd[15] : r_dvd[31]);
    assign w_dvs_neg = r_sgn & (r_m8 ? r_dvs[7] : r_dvs[15]);
    assign w_dvd_raw = r_m8 ? {16'd0, r_dvd[15:0]} : r_dvd;
    assign w_dvd_sx  = r_m8 ? {{16{r_dvd[15]}}, r_dvd[15:0]} : r_dvd;
    assign w_dvd_mag = w_dvd_neg ? (32'd0 - w_dvd_sx) : w_dvd_raw;
    assign w_dvs_raw = r_m8 ? {8'd0, r_dvs[7:0]} : r_dvs;
    assign w_dvs_sx  = r_m8 ? {{8{r_dvs[7]}}, r_dvs[7:0]} : r_dvs;
    assign w_dvs_mag = w_dvs_neg ? (16'd0 - w_dvs_sx) : w_dvs_raw;

    // 8-bit low half sits in the top byte so both widths shift out of bit 15
    assign w_hi = r_m8 ? {8'd0, w_dvd_mag[15:8]} : w_dvd_mag[31:16];
    assign w_lo = r_m8 ? {w_dvd_mag[7:0], 8'd0} : w_dvd_mag[15:0];
    assign w_setup_err = (w_dvs_mag == 16'd0) | (w_hi >= w_dvs_mag);

    assign w_sh  = {r_rem, r_quo[15]};
    assign w_ge  = w_sh >= {1'b0, r_dvs};
    assign w_sub = w_sh[15:0] - r_dvs;

    assign w_mask = r_m8 ? 16'h00FF : 16'hFFFF;
    assign w_lim  = r_m8 ? 16'h0080 : 16'h8000;
    assign w_qmag = r_quo & w_mask;
    assign w_rmag = r_rem & w_mask;
    assign w_qs   = (r_negq ? (16'd0 - w_qmag) : w_qmag) & w_mask;
    assign w_rs   = (r_negr ? (16'd0 - w_rmag) : w_rmag) & w_mask;
    assign w_ovf  = r_sgn & (r_negq ? (w_qmag > w_lim) : (w_qmag >= w_lim));
    assign w_fail = r_err | w_ovf;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_m8      <= 1'b0;
            r_sgn     <= 1'b0;
            r_negq    <= 1'b0;
            r_negr    <= 1'b0;
            r_err     <= 1'b0;
            r_dvd     <= 32'd0;
            r_dvs     <= 16'd0;
            r_rem     <= 16'd0;
            r_quo     <= 16'd0;
            r_cnt     <= 5'd0;
            quotient  <= 16'd0;
            remainder <= 16'd0;
            busy      <= 1'b0;
            complete  <= 1'b0;
            error     <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_m8    <= is_8_bit;
                        r_sgn   <= is_signed;
                        r_dvd   <= dividend;
                        r_dvs   <= divisor;
                        busy    <= 1'b1;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_negq  <= w_dvd_neg ^ w_dvs_neg;
                    r_negr  <= w_dvd_neg;
                    r_dvs   <= w_dvs_mag;
                    r_rem   <= w_hi;
                    r_quo   <= w_lo;
                    r_cnt   <= r_m8 ? 5'd8 : 5'd16;
                    r_err   <= w_setup_err;
                    // early errors still pass through FIXUP to keep a fixed 3-cycle latency
                    r_state <= w_setup_err ? S_FIXUP : S_DIVIDE;
                end
                S_DIVIDE: begin
                    r_rem <= w_ge ? w_sub : w_sh[15:0];
                    r_quo <= {r_quo[14:0], w_ge};
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd1) begin
                        r_state <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    error     <= w_fail;
                    quotient  <= w_fail ? 16'd0 : w_qs;
                    remainder <= w_fail ? 16'd0 : w_rs;
                    busy      <= 1'b0;
                    complete  <= 1'b1;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    complete <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_seq.sv
// Scoreboarded bench for divider_seq against an integer-arithmetic model.
module tb_divider_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        is_8_bit = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = 32'd0;
    logic [15:0] divisor = 16'd0;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        complete;
    logic        error;

    divider_seq dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .is_8_bit  (is_8_bit),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .complete  (complete),
        .error     (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        e;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    function automatic void chk(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Reference: plain integer division with truncation toward zero
    function automatic exp_t model(bit m8, bit sg, logic [31:0] a_in, logic [15:0] b_in);
        exp_t   x;
        longint a, b, q, r, qm, mask, half;
        int     n;
        n = m8 ? 8 : 16;
        if (m8) begin
            a = sg ? longint'($signed(a_in[15:0])) : longint'(a_in[15:0]);
            b = sg ? longint'($signed(b_in[7:0])) : longint'(b_in[7:0]);
        end else begin
            a = sg ? longint'($signed(a_in)) : longint'(a_in);
            b = sg ? longint'($signed(b_in)) : longint'(b_in);
        end
        mask = (longint'(1) << n) - 1;
        half = longint'(1) << (n - 1);
        x.e = 1'b0;
        x.lat = n + 3;
        x.t0 = 0;
        q = 0;
        r = 0;
        if (b == 0) begin
            x.e = 1'b1;
            x.lat = 3;
        end else begin
            q = a / b;
            r = a % b;
            qm = (q < 0) ? -q : q;
            if (qm > mask) begin
                x.e = 1'b1;
                x.lat = 3;
            end else if (sg && ((q < -half) || (q > half - 1))) begin
                x.e = 1'b1;
            end
        end
        x.q = x.e ? 16'd0 : 16'(q & mask);
        x.r = x.e ? 16'd0 : 16'(r & mask);
        return x;
    endfunction

    always @(negedge clk) begin
        if (reset_n && complete) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_complete: got complete=1 expected none (t=%0t)", $time);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("quotient", quotient, x.q);
                chk("remainder", remainder, x.r);
                chk("error", error, x.e);
                chk("latency", cyc - x.t0, x.lat);
                chk("busy_at_complete", busy, 0);
            end
        end
    end

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no complete expected one within 40 cycles");
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic launch(bit m8, bit sg, logic [31:0] a, logic [15:0] b);
        exp_t x;
        @(negedge clk);
        x = model(m8, sg, a, b);
        x.t0 = cyc;
        sb.push_back(x);
        is_8_bit = m8;
        is_signed = sg;
        dividend = a;
        divisor = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_cycle1", busy, 1);
        dividend = $urandom;
        divisor = $urandom;
        is_8_bit = ~m8;
        is_signed = ~sg;
    endtask

    task automatic issue(bit m8, bit sg, logic [31:0] a, logic [15:0] b);
        launch(m8, sg, a, b);
        wait_done();
    endtask

    initial begin
        bit          m8, sg;
        logic [31:0] a;
        logic [15:0] b;

        repeat (3) @(negedge clk);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_busy", busy, 0);
        chk("rst_complete", complete, 0);
        chk("rst_error", error, 0);
        reset_n = 1'b1;
        @(negedge clk);

        issue(1, 0, 32'h0000_0064, 16'h0007);
        issue(0, 1, 32'hFFFF_FC18, 16'h0007);
        issue(0, 0, 32'h0000_1234, 16'h0000);
        issue(1, 0, 32'h0000_0100, 16'h0001);
        issue(1, 0, 32'h0000_00FF, 16'h0001);
        issue(1, 1, 32'h0000_FF80, 16'h0001);
        issue(1, 1, 32'h0000_0080, 16'h0001);
        issue(1, 1, 32'h0000_FF80, 16'h00FF);
        issue(0, 1, 32'hFFFF_8000, 16'h0001);
        issue(0, 1, 32'h0000_8000, 16'h0001);
        issue(1, 0, 32'hABCD_0064, 16'h5507);
        issue(1, 1, 32'h1234_FC18, 16'hAAF9);

        // Extra starts while busy and in the complete cycle must be dropped
        launch(1, 0, 32'h0000_0064, 16'h0007);
        for (int k = 1; k <= 11; k++) begin
            if (k == 3 || k == 8 || k == 11) begin
                dividend = $urandom;
                divisor = 16'($urandom) | 16'd1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        repeat (25) @(negedge clk);
        chk("idle_after_ignored_starts", busy, 0);
        chk("scoreboard_drained", sb.size(), 0);
        sb.delete();

        // Async reset in the middle of DIVIDE
        launch(0, 0, 32'h0001_0000, 16'h0003);
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_quotient", quotient, 0);
        chk("midrst_remainder", remainder, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_complete", complete, 0);
        chk("midrst_error", error, 0);
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        issue(0, 0, 32'h0001_0000, 16'h0003);

        for (int i = 0; i < 80; i++) begin
            m8 = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            a = $urandom;
            b = 16'($urandom);
            if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(0, 4));
            if ($urandom_range(0, 2) != 0) begin
                if (m8) a = a >> $urandom_range(8, 16);
                else a = a >> $urandom_range(16, 32);
            end
            if (sg && $urandom_range(0, 1) == 1) a = 32'd0 - a;
            if (sg && $urandom_range(0, 1) == 1) b = 16'd0 - b;
            issue(m8, sg, a, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
